// File: rtl/vga_pkg.sv
// Shared keypad definitions: key codes, column states, key map.
// Snapshot decode helper used by the scanner.
package vga_pkg;

  localparam logic [3:0] key_0    = 4'h0;
  localparam logic [3:0] key_1    = 4'h1;
  localparam logic [3:0] key_2    = 4'h2;
  localparam logic [3:0] key_3    = 4'h3;
  localparam logic [3:0] key_4    = 4'h4;
  localparam logic [3:0] key_5    = 4'h5;
  localparam logic [3:0] key_6    = 4'h6;
  localparam logic [3:0] key_7    = 4'h7;
  localparam logic [3:0] key_8    = 4'h8;
  localparam logic [3:0] key_9    = 4'h9;
  localparam logic [3:0] key_a    = 4'hA;
  localparam logic [3:0] key_b    = 4'hB;
  localparam logic [3:0] key_c    = 4'hC;
  localparam logic [3:0] key_d    = 4'hD;
  localparam logic [3:0] key_esc  = 4'hE;
  localparam logic [3:0] key_none = 4'hF;

  typedef enum logic [1:0] {
    COL0,
    COL1,
    COL2,
    COL3
  } col_state_t;

  // Indexed by col*4 + row.
  localparam logic [3:0] key_map [16] = '{
    key_1, key_4, key_7, key_0,
    key_2, key_5, key_8, key_none,
    key_3, key_6, key_9, key_esc,
    key_a, key_b, key_c, key_d
  };

  function automatic logic [3:0] snap_decode(
    input logic [15:0] snap
  );
    logic [3:0] code;
    int unsigned hits;
    code = key_none;
    hits = 0;
    for (int i = 0; i < 16; i++) begin
      if (!snap[i]) begin
        hits++;
        code = key_map[i];
      end
    end
    return (hits == 1) ? code : key_none;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Scan-level debounce: a code must repeat DEBOUNCE scans
// in a row before it replaces the accepted code.
module keypad_debounce
  import vga_pkg::*;
#(
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw,
  input  logic       scan_done,
  output logic [3:0] accepted,
  output logic       change
);

  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

  logic [3:0]    cand;
  logic [CW-1:0] stable_cnt;
  logic [3:0]    cand_nxt;
  logic [CW-1:0] cnt_nxt;

  always_comb begin
    cand_nxt = cand;
    cnt_nxt  = stable_cnt;
    if (raw == cand) begin
      if (stable_cnt != CNT_MAX)
        cnt_nxt = stable_cnt + 1'b1;
    end else begin
      cand_nxt = raw;
      cnt_nxt  = CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cand       <= key_none;
      stable_cnt <= '0;
      accepted   <= key_none;
      change     <= 1'b0;
    end else begin
      change <= 1'b0;
      if (scan_done) begin
        cand       <= cand_nxt;
        stable_cnt <= cnt_nxt;
        if (cnt_nxt == CNT_MAX && cand_nxt != accepted) begin
          accepted <= cand_nxt;
          change   <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row snapshot, ghost reject,
// debounce and one-cycle key strobe.
module keypad_scanner
  import vga_pkg::*;
#(
  parameter int COL_DWELL = 1000,
  parameter int DEBOUNCE  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW = $clog2(COL_DWELL);
  localparam logic [DW-1:0] DWELL_LAST = DW'(COL_DWELL - 1);

  logic [3:0]    row_s1;
  logic [3:0]    row_s2;
  col_state_t    state;
  logic [DW-1:0] dwell;
  logic [3:0]    row_snap [4];
  logic          scan_done;
  logic [3:0]    raw;
  logic [3:0]    accepted;
  logic          change;

  always_ff @(posedge clk) begin
    if (rst) begin
      row_s1    <= 4'hF;
      row_s2    <= 4'hF;
      state     <= COL0;
      dwell     <= '0;
      col       <= 4'b1110;
      scan_done <= 1'b0;
      for (int i = 0; i < 4; i++)
        row_snap[i] <= 4'hF;
    end else begin
      row_s1    <= row;
      row_s2    <= row_s1;
      scan_done <= 1'b0;
      if (dwell == DWELL_LAST) begin
        dwell           <= '0;
        row_snap[state] <= row_s2;
        unique case (state)
          COL0: begin
            state <= COL1;
            col   <= 4'b1101;
          end
          COL1: begin
            state <= COL2;
            col   <= 4'b1011;
          end
          COL2: begin
            state <= COL3;
            col   <= 4'b0111;
          end
          COL3: begin
            state     <= COL0;
            col       <= 4'b1110;
            scan_done <= 1'b1;
          end
        endcase
      end else begin
        dwell <= dwell + 1'b1;
      end
    end
  end

  assign raw = snap_decode({row_snap[3], row_snap[2],
                            row_snap[1], row_snap[0]});

  keypad_debounce #(
    .DEBOUNCE(DEBOUNCE)
  ) u_debounce (
    .clk      (clk),
    .rst      (rst),
    .raw      (raw),
    .scan_done(scan_done),
    .accepted (accepted),
    .change   (change)
  );

  // Releases update key_held but never strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      key       <= key_none;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
    end else begin
      key_valid <= change && (accepted != key_none);
      key       <= (change && accepted != key_none)
                   ? accepted : key_none;
      key_held  <= (accepted != key_none);
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed and randomized checks of keypad_scanner against
// a behavioural keypad and key-code model.
module tb_keypad_scanner;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic [3:0]  key;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = '0;

  int vectors = 0;
  int miscompares = 0;
  int strobes = 0;
  int bad_out = 0;
  int bad_col = 0;
  logic [3:0] last_key = 4'hF;

  always #5 clk = ~clk;

  keypad_scanner #(
    .COL_DWELL(4),
    .DEBOUNCE (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row      (row),
    .col      (col),
    .key      (key),
    .key_valid(key_valid),
    .key_held (key_held)
  );

  // Keypad: pressed index r*4+c shorts row r to col c.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r*4+c] && !col[c])
          row[r] = 1'b0;
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (key_valid) begin
        strobes  <= strobes + 1;
        last_key <= key;
      end
      if ((key_valid && key == 4'hF) || (!key_valid && key != 4'hF))
        bad_out <= bad_out + 1;
      if (!(col inside {4'hE, 4'hD, 4'hB, 4'h7}))
        bad_col <= bad_col + 1;
    end
  end

  function automatic logic [3:0] key_code(input int r, input int c);
    if (c == 3) return 4'(10 + r);
    if (r < 3)  return 4'(r * 3 + c + 1);
    if (c == 0) return 4'h0;
    if (c == 1) return 4'hF;
    return 4'hE;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_strobe(input int s0, input int budget);
    for (int i = 0; i < budget && strobes == s0; i++)
      @(posedge clk);
    #1;
  endtask

  initial begin
    int s0;
    int drops;
    int r;
    int c;
    logic [3:0] pat [4];
    pat[0] = 4'hE; pat[1] = 4'hD; pat[2] = 4'hB; pat[3] = 4'h7;

    // 1: reset and idle scanning
    rst = 1'b1;
    step(5);
    check("rst_col", col, 4'hE);
    check("rst_key", key, 4'hF);
    check("rst_valid", key_valid, 0);
    check("rst_held", key_held, 0);
    rst = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check("col_seq", col, pat[(k / 4) % 4]);
      step(1);
    end
    step(200);
    check("idle_strobes", strobes, 0);

    // 2: press '2' and hold
    s0 = strobes;
    pressed[0*4+1] = 1'b1;
    wait_strobe(s0, 68);
    check("t2_strobe", strobes - s0, 1);
    check("t2_key", last_key, 4'h2);
    s0 = strobes;
    drops = 0;
    for (int i = 0; i < 500; i++) begin
      step(1);
      if (!key_held) drops++;
    end
    check("t2_held", drops, 0);
    check("t2_norepeat", strobes - s0, 0);
    pressed = '0;
    step(150);
    check("t2_release", key_held, 0);

    // 3: 'E' press, release, press
    s0 = strobes;
    pressed[3*4+2] = 1'b1;
    step(100);
    pressed = '0;
    step(100);
    check("t3_held_fall", key_held, 0);
    pressed[3*4+2] = 1'b1;
    step(100);
    check("t3_strobes", strobes - s0, 2);
    check("t3_key", last_key, 4'hE);
    pressed = '0;
    step(150);

    // 4: bounce on '4'
    s0 = strobes;
    for (int i = 0; i < 10; i++) begin
      pressed[1*4+0] = ~pressed[1*4+0];
      step(16);
    end
    check("t4_bounce", strobes - s0, 0);
    pressed[1*4+0] = 1'b1;
    wait_strobe(s0, 100);
    check("t4_strobe", strobes - s0, 1);
    check("t4_key", last_key, 4'h4);
    pressed = '0;
    step(150);

    // 5: ghost '1'+'5', then release '5'
    s0 = strobes;
    pressed[0*4+0] = 1'b1;
    pressed[1*4+1] = 1'b1;
    step(150);
    check("t5_ghost", strobes - s0, 0);
    check("t5_ghost_held", key_held, 0);
    pressed[1*4+1] = 1'b0;
    wait_strobe(s0, 100);
    check("t5_strobe", strobes - s0, 1);
    check("t5_key", last_key, 4'h1);
    pressed = '0;
    step(150);

    // 6: 'F' never reported; 'A' re-reported after reset
    s0 = strobes;
    pressed[3*4+1] = 1'b1;
    step(150);
    check("t6_f", strobes - s0, 0);
    check("t6_f_held", key_held, 0);
    pressed = '0;
    step(150);
    pressed[0*4+3] = 1'b1;
    wait_strobe(s0, 100);
    check("t6_a", last_key, 4'hA);
    step(7);
    rst = 1'b1;
    step(1);
    check("t6_rst_col", col, 4'hE);
    check("t6_rst_key", key, 4'hF);
    check("t6_rst_valid", key_valid, 0);
    check("t6_rst_held", key_held, 0);
    rst = 1'b0;
    step(120);
    check("t6_rereport", strobes - s0, 2);
    check("t6_rekey", last_key, 4'hA);
    check("t6_reheld", key_held, 1);
    pressed = '0;
    step(150);

    // Random single-key presses
    for (int n = 0; n < 10; n++) begin
      r = $urandom_range(0, 3);
      c = $urandom_range(0, 3);
      if (r == 3 && c == 1) c = 0;
      s0 = strobes;
      pressed[r*4+c] = 1'b1;
      step(100 + $urandom_range(0, 100));
      check("rnd_strobe", strobes - s0, 1);
      check("rnd_key", last_key, key_code(r, c));
      check("rnd_held", key_held, 1);
      pressed = '0;
      step(150);
      check("rnd_release", key_held, 0);
    end

    check("out_consistency", bad_out, 0);
    check("col_onehot", bad_col, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
